// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//   Shared definitions for the sequential branch-condition unit:
//   - branch condition codes (OP_BEQ .. OP_BLT)
//   - FSM state encoding (ST_IDLE, ST_SCAN, ST_DONE)
//   - is_zero_op(): true for ops that compare rs against zero
//     (BGEZ, BGTZ, BLTZ, BLEZ)
// ---------------------------------------------------------------------------
package cmp_pkg;

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BGEZ = 3'd2;
  localparam logic [2:0] OP_BGTZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;
  localparam logic [2:0] OP_BLEZ = 3'd5;
  localparam logic [2:0] OP_BLTU = 3'd6;
  localparam logic [2:0] OP_BLT  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_zero_op(input logic [2:0] op);
    return (op >= OP_BGEZ) && (op <= OP_BLEZ);
  endfunction

endpackage

// File: rtl/chunk_cmp.sv
// ---------------------------------------------------------------------------
// chunk_cmp
//   Combinational compare of one CHUNK-bit slice of the operands.
//   Ports:
//     a, b  : CHUNK-bit slices of rs and rt
//     eq    : a == b
//     ltu   : a <  b (unsigned)
// ---------------------------------------------------------------------------
module chunk_cmp #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             ltu
);

  assign eq  = (a == b);
  assign ltu = (a < b);

endmodule

// File: rtl/branch_compare_seq.sv
// ---------------------------------------------------------------------------
// branch_compare_seq
//   Sequential branch-condition unit. Compares rs and rt CHUNK bits per
//   cycle starting from the most significant chunk; the first differing
//   chunk decides the unsigned ordering, the sign bits fix up the signed one.
//
//   Ports:
//     clk, reset   : clock, asynchronous active-high reset
//     start        : request, sampled only in IDLE
//     op           : condition code (see cmp_pkg)
//     rs, rt       : operands (rt replaced by 0 for zero-compare ops)
//     busy         : high while scanning
//     done         : one-cycle pulse when results are updated
//     taken        : branch decision (held)
//     equal_out    : operands equal (held)
//     lt_unsigned  : rs < rt unsigned (held)
//     lt_signed    : rs < rt two's complement (held)
//
//   Build option: CMP_EARLY_EXIT_EN -- when defined the scan stops at the
//   first differing chunk; otherwise it always runs all chunks. Results are
//   the same either way, only latency differs.
// ---------------------------------------------------------------------------
module branch_compare_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             equal_out,
  output logic             lt_unsigned,
  output logic             lt_signed
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             decided;
  logic             ltu_rec;
  logic             scan_end;

  logic [WIDTH-1:0] rs_p0, rt_p0;
  logic [2:0]       op_p0;

  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_eq, c_ltu;
  logic             dec_nxt, ltu_nxt, lts_nxt;

  function automatic logic branch_taken(input logic [2:0] code,
                                        input logic       eq,
                                        input logic       ltu,
                                        input logic       lts);
    logic t;
    t = 1'b0;
    unique case (code)
      OP_BEQ:  t = eq;
      OP_BNE:  t = !eq;
      OP_BGEZ: t = !lts;
      OP_BGTZ: t = !lts && !eq;
      OP_BLTZ: t = lts;
      OP_BLEZ: t = lts || eq;
      OP_BLTU: t = ltu;
      OP_BLT:  t = lts;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Single chunk comparator, fed by the chunk selected by idx
  assign a_chunk = rs_p0[int'(idx)*CHUNK +: CHUNK];
  assign b_chunk = rt_p0[int'(idx)*CHUNK +: CHUNK];

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .a   (a_chunk),
    .b   (b_chunk),
    .eq  (c_eq),
    .ltu (c_ltu)
  );

  // Fold the current chunk into the decision so the results can be
  // registered on the same edge that leaves SCAN.
  assign dec_nxt = decided || !c_eq;
  assign ltu_nxt = (!decided && !c_eq) ? c_ltu : ltu_rec;
  assign lts_nxt = (rs_p0[WIDTH-1] != rt_p0[WIDTH-1]) ? rs_p0[WIDTH-1] : ltu_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    scan_end  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        busy = 1'b1;
`ifdef CMP_EARLY_EXIT_EN
        scan_end = !c_eq || (idx == '0);
`else
        scan_end = (idx == '0);
`endif
        if (scan_end) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stage p0: operand capture at accept (data only, no reset)
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      rs_p0 <= rs;
      rt_p0 <= is_zero_op(op) ? '0 : rt;
      op_p0 <= op;
    end
  end

  // Scan control and held results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= '0;
      decided     <= 1'b0;
      ltu_rec     <= 1'b0;
      taken       <= 1'b0;
      equal_out   <= 1'b0;
      lt_unsigned <= 1'b0;
      lt_signed   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            idx     <= IDX_W'(NCHUNK - 1);
            decided <= 1'b0;
            ltu_rec <= 1'b0;
          end
        end
        ST_SCAN: begin
          decided <= dec_nxt;
          ltu_rec <= ltu_nxt;
          if (scan_end) begin
            equal_out   <= !dec_nxt;
            lt_unsigned <= ltu_nxt;
            lt_signed   <= lts_nxt;
            taken       <= branch_taken(op_p0, !dec_nxt, ltu_nxt, lts_nxt);
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_compare_seq.sv
module tb_branch_compare_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_i, rt_i;
  logic             busy, done, taken, equal_out, lt_unsigned, lt_signed;

  typedef struct {
    logic        taken;
    logic        eq;
    logic        ltu;
    logic        lts;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  branch_compare_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op_i),
    .rs          (rs_i),
    .rt          (rt_i),
    .busy        (busy),
    .done        (done),
    .taken       (taken),
    .equal_out   (equal_out),
    .lt_unsigned (lt_unsigned),
    .lt_signed   (lt_signed)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic on whole operands
  function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b_in);
    exp_t             e;
    logic [WIDTH-1:0] b;
    b = (op >= 3'd2 && op <= 3'd5) ? '0 : b_in;
    e.eq  = (a == b);
    e.ltu = (a < b);
    e.lts = ($signed(a) < $signed(b));
    case (op)
      3'd0: e.taken = e.eq;
      3'd1: e.taken = !e.eq;
      3'd2: e.taken = !e.lts;
      3'd3: e.taken = !e.lts && !e.eq;
      3'd4: e.taken = e.lts;
      3'd5: e.taken = e.lts || e.eq;
      3'd6: e.taken = e.ltu;
      default: e.taken = e.lts;
    endcase
    e.lat = NCHUNK;
`ifdef CMP_EARLY_EXIT_EN
    for (int k = NCHUNK - 1; k >= 0; k--) begin
      if (a[k*CHUNK +: CHUNK] != b[k*CHUNK +: CHUNK]) begin
        e.lat = NCHUNK - k;
        break;
      end
    end
`endif
    e.acc = 0;
    return e;
  endfunction

  // Monitor: compare whenever the DUT signals done
  always @(negedge clk) begin
    if (!reset) begin
      if (busy && done) chk("busy_done_overlap", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("taken",       taken,       e.taken);
          chk("equal_out",   equal_out,   e.eq);
          chk("lt_unsigned", lt_unsigned, e.ltu);
          chk("lt_signed",   lt_signed,   e.lts);
          chk("latency",     cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("timeout_idle", 1, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("timeout_done", 1, 0);
  endtask

  task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    exp_t e;
    @(negedge clk);
    wait_idle();
    start = 1'b1;
    op_i  = op;
    rs_i  = a;
    rt_i  = b;
    e     = model(op, a, b);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    op_i  = 3'($urandom);
    rs_i  = $urandom;
    rt_i  = $urandom;
  endtask

  task automatic run_cmp(input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input bit mid_start);
    issue(op, a, b);
    if (mid_start) begin
      @(negedge clk);
      chk("busy_mid_scan", busy, 1);
      start = 1'b1;
      op_i  = 3'd1;
      rs_i  = ~a;
      rt_i  = a;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(negedge clk);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    reset = 1'b1;
    start = 1'b0;
    op_i  = '0;
    rs_i  = '0;
    rt_i  = '0;
    #1;
    chk("rst_busy",  busy,        0);
    chk("rst_done",  done,        0);
    chk("rst_taken", taken,       0);
    chk("rst_eq",    equal_out,   0);
    chk("rst_ltu",   lt_unsigned, 0);
    chk("rst_lts",   lt_signed,   0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_cmp(3'd0, 32'h12345678, 32'h12345678, 0);
    run_cmp(3'd1, 32'h80000000, 32'h00000000, 0);
    run_cmp(3'd6, 32'h00000001, 32'h00000002, 0);
    run_cmp(3'd7, 32'hFFFFFFFF, 32'h00000001, 0);
    run_cmp(3'd3, 32'hFFFFFFFF, 32'hDEADBEEF, 0);
    run_cmp(3'd5, 32'h00000000, 32'h55AA55AA, 0);
    run_cmp(3'd2, 32'h7FFFFFFF, 32'h80000000, 0);
    run_cmp(3'd4, 32'h00000000, 32'hFFFFFFFF, 0);

    // Second start during scan is ignored
    run_cmp(3'd0, 32'hCAFEF00D, 32'hCAFEF00D, 1);
    repeat (3) @(negedge clk);
    chk("single_done", done, 0);

    // Leave nonzero results, then reset in the middle of a scan
    run_cmp(3'd7, 32'hFFFFFFFF, 32'h00000001, 0);
    issue(3'd0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy",  busy,        0);
    chk("midrst_done",  done,        0);
    chk("midrst_taken", taken,       0);
    chk("midrst_eq",    equal_out,   0);
    chk("midrst_ltu",   lt_unsigned, 0);
    chk("midrst_lts",   lt_signed,   0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    run_cmp(3'd1, 32'h00000001, 32'h00000000, 0);

    // Randomized: mix fully random operands with ones sharing upper chunks
    for (int i = 0; i < 300; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = $urandom;
        1: b = a;
        default: begin
          int k;
          b = a;
          k = $urandom_range(0, NCHUNK - 1);
          b[k*CHUNK +: CHUNK] = 8'($urandom);
        end
      endcase
      if ($urandom_range(0, 7) == 0) a = '0;
      run_cmp(op, a, b, 0);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
